// File: rtl/wide_subadd_sequencer_if.sv
// Bundle of the operand/result handshakes and the 16-bit adder slice port
// shared between the wide add/sub sequencer and its environment.
interface wide_subadd_sequencer_if #(parameter int WIDTH = 64);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             busy;
  logic [15:0]      add_x1;
  logic [15:0]      add_x2;
  logic             add_cin;
  logic [15:0]      add_s;
  logic             add_p;
  logic             add_g;

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready, add_s, add_p, add_g,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, busy,
           add_x1, add_x2, add_cin
  );

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready, add_s, add_p, add_g,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy,
           add_x1, add_x2, add_cin
  );
endinterface

// File: rtl/wide_subadd_sequencer.sv
// Sequences a WIDTH-bit add/subtract through an external 16-bit adder, one
// slice per cycle, rippling the carry via the adder's group propagate/generate.
module wide_subadd_sequencer #(
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  wide_subadd_sequencer_if.slave bus
);
  localparam int NSLICE = WIDTH / 16;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry;
  logic             cout_reg;
  logic             ovf_reg;
  logic             carry_nxt;

  assign carry_nxt = bus.add_g | (bus.add_p & carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Adder inputs are gated to zero outside RUN so the slice adder stays quiet.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.add_x1    = 16'h0;
    bus.add_x2    = 16'h0;
    bus.add_cin   = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = RUN;
      end
      RUN: begin
        bus.busy    = 1'b1;
        bus.add_x1  = a_reg[16*idx +: 16];
        bus.add_x2  = b_reg[16*idx +: 16];
        bus.add_cin = carry;
        if (idx == LAST) state_nxt = DONE;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction is folded in at capture: B is inverted and the carry seeded with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.in_valid) begin
        a_reg <= bus.in_a;
        b_reg <= bus.in_sub ? ~bus.in_b : bus.in_b;
        idx   <= '0;
        carry <= bus.in_sub;
      end
    end else if (state == RUN) begin
      sum_reg[16*idx +: 16] <= bus.add_s;
      carry                 <= carry_nxt;
      if (idx == LAST) begin
        idx      <= '0;
        cout_reg <= carry_nxt;
        ovf_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &
                    (bus.add_s[15] != a_reg[WIDTH-1]);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign bus.out_sum  = sum_reg;
  assign bus.out_cout = cout_reg;
  assign bus.out_ovf  = ovf_reg;
endmodule
